// File: rtl/vc_iterative_divider_pkg.sv
// Shared definitions for the iterative divider: FSM states and counter sizing.
package vc_iterative_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must reach nbits inclusive (nbits steps plus the sign-fixup cycle)
    function automatic int cnt_width(input int nbits);
        return $clog2(nbits + 1);
    endfunction

endpackage

// File: rtl/vc_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module vc_div_step #(
    parameter int p_nbits = 32
) (
    input  logic [p_nbits:0]   rem,
    input  logic [p_nbits-1:0] divisor,
    input  logic               next_bit,
    output logic [p_nbits:0]   new_rem,
    output logic               qbit
);

    logic [p_nbits+1:0] shifted;
    logic [p_nbits+1:0] diff;

    // One extra bit so the trial difference carries its own sign
    always_comb begin
        shifted = {rem, next_bit};
        diff    = shifted - {2'b00, divisor};
        qbit    = ~diff[p_nbits+1];
        new_rem = qbit ? diff[p_nbits:0] : shifted[p_nbits:0];
    end

endmodule

// File: rtl/vc_iterative_divider.sv
// Multi-cycle signed/unsigned divider with val/rdy handshakes and a domain tag.
module vc_iterative_divider
    import vc_iterative_divider_pkg::*;
#(
    parameter int p_nbits = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               req_val,
    output logic               req_rdy,
    input  logic               req_domain,
    input  logic               req_signed,
    input  logic [p_nbits-1:0] req_a,
    input  logic [p_nbits-1:0] req_b,
    output logic               resp_val,
    input  logic               resp_rdy,
    output logic               resp_domain,
    output logic [p_nbits-1:0] resp_quot,
    output logic [p_nbits-1:0] resp_rem
);

    localparam int CW = cnt_width(p_nbits);
    localparam logic [CW-1:0] LAST = CW'(p_nbits);

    state_t             state, next_state;
    logic [CW-1:0]      cnt_q;
    logic [p_nbits:0]   rem_q;
    logic [p_nbits-1:0] dvd_q;
    logic [p_nbits-1:0] div_q;
    logic               neg_q;
    logic               neg_r;
    logic               dbz_q;
    logic               a_neg;
    logic               b_neg;
    logic               accept;
    logic [p_nbits:0]   step_rem;
    logic               step_q;

    assign a_neg  = req_signed & req_a[p_nbits-1];
    assign b_neg  = req_signed & req_b[p_nbits-1];
    assign accept = req_val & req_rdy;

    vc_div_step #(.p_nbits(p_nbits)) u_step (
        .rem      (rem_q),
        .divisor  (div_q),
        .next_bit (dvd_q[p_nbits-1]),
        .new_rem  (step_rem),
        .qbit     (step_q)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        req_rdy    = 1'b0;
        resp_val   = 1'b0;
        case (state)
            IDLE: begin
                req_rdy = 1'b1;
                if (req_val) next_state = CALC;
            end
            CALC: if (cnt_q == LAST) next_state = DONE;
            DONE: begin
                resp_val = 1'b1;
                if (resp_rdy) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Dividend register doubles as quotient register: quotient bits shift in from the bottom.
    // The cycle after the last step applies signs; a zero divisor keeps the all-ones quotient.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q       <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            div_q       <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dbz_q       <= 1'b0;
            resp_domain <= 1'b0;
            resp_quot   <= '0;
            resp_rem    <= '0;
        end else if (state == IDLE) begin
            if (accept) begin
                cnt_q       <= '0;
                rem_q       <= '0;
                dvd_q       <= a_neg ? -req_a : req_a;
                div_q       <= b_neg ? -req_b : req_b;
                neg_q       <= a_neg ^ b_neg;
                neg_r       <= a_neg;
                dbz_q       <= (req_b == '0);
                resp_domain <= req_domain;
            end
        end else if (state == CALC) begin
            if (cnt_q == LAST) begin
                resp_quot <= (neg_q && !dbz_q) ? -dvd_q : dvd_q;
                resp_rem  <= neg_r ? -rem_q[p_nbits-1:0] : rem_q[p_nbits-1:0];
            end else begin
                rem_q <= step_rem;
                dvd_q <= {dvd_q[p_nbits-2:0], step_q};
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vc_iterative_divider.sv
// Randomized and directed self-checking bench for vc_iterative_divider against an arithmetic model.
module tb_vc_iterative_divider;

    localparam int N = 32;

    logic         clk;
    logic         reset_n;
    logic         req_val;
    logic         req_rdy;
    logic         req_domain;
    logic         req_signed;
    logic [N-1:0] req_a;
    logic [N-1:0] req_b;
    logic         resp_val;
    logic         resp_rdy;
    logic         resp_domain;
    logic [N-1:0] resp_quot;
    logic [N-1:0] resp_rem;

    int checks = 0;
    int errors = 0;

    vc_iterative_divider #(.p_nbits(N)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_val     (req_val),
        .req_rdy     (req_rdy),
        .req_domain  (req_domain),
        .req_signed  (req_signed),
        .req_a       (req_a),
        .req_b       (req_b),
        .resp_val    (resp_val),
        .resp_rdy    (resp_rdy),
        .resp_domain (resp_domain),
        .resp_quot   (resp_quot),
        .resp_rem    (resp_rem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain integer division, truncating toward zero, with the divider's corner cases
    function automatic void refDiv(input logic sgn, input logic [N-1:0] a, input logic [N-1:0] b,
                                   output logic [N-1:0] q, output logic [N-1:0] r);
        longint sa, sb;
        if (b == 0) begin
            q = '1;
            r = a;
        end else if (!sgn) begin
            q = a / b;
            r = a % b;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q = N'(sa / sb);
            r = N'(sa % sb);
        end
    endfunction

    task automatic waitReady();
        int n = 0;
        while (!req_rdy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_rdy) checkOutput("ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic waitResp(output int lat);
        lat = 0;
        while (!resp_val && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic applyStimulus(input logic sgn, input logic [N-1:0] a, input logic [N-1:0] b,
                                 input logic dom, input int stall);
        logic [N-1:0] eq, er;
        int lat;
        refDiv(sgn, a, b, eq, er);
        waitReady();
        req_val = 1'b1; req_signed = sgn; req_a = a; req_b = b; req_domain = dom;
        @(negedge clk);
        req_val = 1'b0;
        req_domain = ~dom;
        checkOutput("busy_rdy", 64'(req_rdy), 64'd0);
        waitResp(lat);
        checkOutput("latency", 64'(lat), 64'(N + 1));
        checkOutput("quot", 64'(resp_quot), 64'(eq));
        checkOutput("rem", 64'(resp_rem), 64'(er));
        checkOutput("domain", 64'(resp_domain), 64'(dom));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            checkOutput("hold_quot", 64'(resp_quot), 64'(eq));
            checkOutput("hold_val", 64'(resp_val), 64'd1);
        end
        resp_rdy = 1'b1;
        @(negedge clk);
        resp_rdy = 1'b0;
        checkOutput("idle_rdy", 64'(req_rdy), 64'd1);
    endtask

    initial begin
        logic [N-1:0] eq, er, ra, rb;
        int lat;

        reset_n = 1'b0; req_val = 1'b0; req_domain = 1'b0; req_signed = 1'b0;
        req_a = '0; req_b = '0; resp_rdy = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_rdy", 64'(req_rdy), 64'd1);
        checkOutput("rst_val", 64'(resp_val), 64'd0);
        checkOutput("rst_dom", 64'(resp_domain), 64'd0);
        checkOutput("rst_quot", 64'(resp_quot), 64'd0);
        checkOutput("rst_rem", 64'(resp_rem), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Directed corner cases
        applyStimulus(1'b0, 32'd100, 32'd7, 1'b0, 0);
        applyStimulus(1'b1, -32'sd100, 32'd7, 1'b1, 0);
        applyStimulus(1'b1, 32'd100, -32'sd7, 1'b0, 2);
        applyStimulus(1'b0, 32'h1234, 32'd0, 1'b1, 0);
        applyStimulus(1'b1, 32'd5, 32'd0, 1'b0, 0);
        applyStimulus(1'b1, -32'sd5, 32'd0, 1'b0, 0);
        applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
        applyStimulus(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, 0);

        // Backpressure with a toggling domain and a request held valid throughout
        waitReady();
        req_val = 1'b1; req_signed = 1'b0; req_a = 32'd1000; req_b = 32'd9; req_domain = 1'b1;
        refDiv(1'b0, 32'd1000, 32'd9, eq, er);
        @(negedge clk);
        lat = 0;
        while (!resp_val && lat < 100) begin
            req_domain = ~req_domain;
            @(negedge clk);
            lat++;
        end
        checkOutput("bp_latency", 64'(lat), 64'(N + 1));
        for (int i = 0; i < 10; i++) begin
            checkOutput("bp_quot", 64'(resp_quot), 64'(eq));
            checkOutput("bp_rem", 64'(resp_rem), 64'(er));
            checkOutput("bp_dom", 64'(resp_domain), 64'd1);
            checkOutput("bp_rdy", 64'(req_rdy), 64'd0);
            req_domain = ~req_domain;
            @(negedge clk);
        end
        req_domain = 1'b0; req_a = 32'd50; req_b = 32'd5;
        resp_rdy = 1'b1;
        @(negedge clk);
        resp_rdy = 1'b0;
        checkOutput("bp_after_rdy", 64'(req_rdy), 64'd1);
        checkOutput("bp_after_val", 64'(resp_val), 64'd0);
        @(negedge clk);
        req_val = 1'b0;
        checkOutput("bp_next_acc", 64'(req_rdy), 64'd0);
        waitResp(lat);
        checkOutput("bp2_latency", 64'(lat), 64'(N + 1));
        checkOutput("bp2_quot", 64'(resp_quot), 64'd10);
        checkOutput("bp2_rem", 64'(resp_rem), 64'd0);
        checkOutput("bp2_dom", 64'(resp_domain), 64'd0);
        resp_rdy = 1'b1;
        @(negedge clk);
        resp_rdy = 1'b0;

        // Asynchronous reset in the middle of a computation
        waitReady();
        req_val = 1'b1; req_signed = 1'b0; req_a = 32'd1000; req_b = 32'd7;
        @(negedge clk);
        req_val = 1'b0;
        repeat (10) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("arst_rdy", 64'(req_rdy), 64'd1);
        checkOutput("arst_val", 64'(resp_val), 64'd0);
        checkOutput("arst_quot", 64'(resp_quot), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        applyStimulus(1'b0, 32'd9, 32'd3, 1'b1, 0);

        // Randomized operations with occasional zero divisors, overflow and backpressure
        for (int k = 0; k < 40; k++) begin
            ra = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'($urandom_range(0, 15));
                1: rb = '0;
                2: rb = ra >> $urandom_range(1, 30);
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) begin
                ra = 32'h8000_0000;
                rb = 32'hFFFF_FFFF;
            end
            applyStimulus(1'($urandom_range(0, 1)), ra, rb, 1'($urandom_range(0, 1)),
                          int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
